// File: rtl/load_store_unit_if.sv
// Bus bundle between execute/writeback, the load/store unit and the data memory.
// The slave modport is the load/store unit's view; master is the surrounding pipeline and memory.
interface load_store_unit_if #(
   parameter int unsigned FCNT_W = 8
);
   logic              memReq;
   logic              memWe;
   logic [2:0]        funct3;
   logic [31:0]       addr;
   logic [31:0]       storeData;
   logic [31:0]       loadData;
   logic              stall;
   logic              fault;
   logic [FCNT_W-1:0] faultCount;
   logic [31:0]       lastFaultAddr;
   logic              dmemRead;
   logic              dmemWrite;
   logic [31:0]       dmemAddr;
   logic [31:0]       dmemWriteData;
   logic [31:0]       dmemReadData;

   modport slave (
      input  memReq, memWe, funct3, addr, storeData, dmemReadData,
      output loadData, stall, fault, faultCount, lastFaultAddr,
             dmemRead, dmemWrite, dmemAddr, dmemWriteData
   );

   modport master (
      output memReq, memWe, funct3, addr, storeData, dmemReadData,
      input  loadData, stall, fault, faultCount, lastFaultAddr,
             dmemRead, dmemWrite, dmemAddr, dmemWriteData
   );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage front end: byte-addressed RV32 loads/stores onto a word-only data memory,
// with sub-word stores done as a two-cycle read-modify-write and fault detection/counting.
module load_store_unit #(
   parameter int unsigned DEPTH  = 512,
   parameter int unsigned FCNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   load_store_unit_if.slave bus
);
   typedef enum logic {
      IDLE = 1'b0,
      RMW  = 1'b1
   } state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_e            state_q;
   logic [31:0]       merge_q;
   logic [31:0]       merge_d;
   logic [FCNT_W-1:0] fcnt_q;
   logic [31:0]       last_fault_q;

   logic        req_idle;
   logic        is_half;
   logic        is_word;
   logic        misaligned;
   logic        out_of_range;
   logic        bad_funct3;
   logic        fault;
   logic        do_load;
   logic        do_sw;
   logic        do_subword;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_ext;

   // Requests are only decoded in IDLE; the RMW cycle ignores whatever sits on the inputs.
   assign req_idle     = (state_q == IDLE) && bus.memReq;
   assign is_half      = (bus.funct3 == F3_H) || (bus.funct3 == F3_HU);
   assign is_word      = (bus.funct3 == F3_W);
   assign misaligned   = (is_half && bus.addr[0]) || (is_word && (bus.addr[1:0] != 2'b00));
   assign out_of_range = {2'b00, bus.addr[31:2]} >= 32'(DEPTH);

   always_comb begin
      if (bus.memWe) begin
         bad_funct3 = !(bus.funct3 inside {F3_B, F3_H, F3_W});
      end else begin
         bad_funct3 = !(bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      end
   end

   assign fault      = req_idle && (misaligned || out_of_range || bad_funct3);
   assign do_load    = req_idle && !fault && !bus.memWe;
   assign do_sw      = req_idle && !fault && bus.memWe && is_word;
   assign do_subword = req_idle && !fault && bus.memWe && !is_word;

   assign lane_byte = bus.dmemReadData[{bus.addr[1:0], 3'b000} +: 8];
   assign lane_half = bus.dmemReadData[{bus.addr[1], 4'b0000} +: 16];

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      load_ext = bus.dmemReadData;
      case (bus.funct3)
         F3_B:    load_ext = {{24{lane_byte[7]}}, lane_byte};
         F3_BU:   load_ext = {24'h0, lane_byte};
         F3_H:    load_ext = {{16{lane_half[15]}}, lane_half};
         F3_HU:   load_ext = {16'h0, lane_half};
         default: load_ext = bus.dmemReadData;
      endcase
   end

   always_comb begin
      merge_d = bus.dmemReadData;
      if (bus.funct3 == F3_H) begin
         merge_d[{bus.addr[1], 4'b0000} +: 16] = bus.storeData[15:0];
      end else begin
         merge_d[{bus.addr[1:0], 3'b000} +: 8] = bus.storeData[7:0];
      end
   end

   assign bus.loadData      = do_load ? load_ext : 32'h0;
   assign bus.stall         = do_subword;
   assign bus.fault         = fault;
   assign bus.dmemRead      = do_load || do_subword;
   assign bus.dmemWrite     = do_sw || (state_q == RMW);
   assign bus.dmemAddr      = {2'b00, bus.addr[31:2]};
   assign bus.dmemWriteData = (state_q == RMW) ? merge_q : bus.storeData;
   assign bus.faultCount    = fcnt_q;
   assign bus.lastFaultAddr = last_fault_q;

   // NOTE: sequential state uses non-blocking assignments only; the merge word is a plain
   // register (not a memory), so it is reset along with the rest of the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         merge_q      <= 32'h0;
         fcnt_q       <= '0;
         last_fault_q <= 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (do_subword) begin
                  merge_q <= merge_d;
                  state_q <= RMW;
               end
            end
            RMW:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (fault) begin
            last_fault_q <= bus.addr;
            if (fcnt_q != '1) begin
               fcnt_q <= fcnt_q + FCNT_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table for single-cycle accesses and faults,
// plus hand-written sequences for reset-during-RMW, sub-word stores, idle gaps and saturation.
module tb_load_store_unit;
   logic clk;
   logic rst_n;

   load_store_unit_if #(.FCNT_W(8)) bus ();

   load_store_unit #(.DEPTH(512), .FCNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [0:511];
   assign bus.dmemReadData = mem[bus.dmemAddr[8:0]];

   int n_vec  = 0;
   int n_miss = 0;
   int wr_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negative edge: capture the write strobe, commit it at the next rising edge.
   task automatic tick();
      logic        we;
      logic [8:0]  idx;
      logic [31:0] wd;
      we  = bus.dmemWrite;
      idx = bus.dmemAddr[8:0];
      wd  = bus.dmemWriteData;
      @(posedge clk);
      if (we) begin
         mem[idx] = wd;
         wr_cnt++;
      end
      #1;
   endtask

   task automatic drive(input logic req, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
      bus.memReq    = req;
      bus.memWe     = we;
      bus.funct3    = f3;
      bus.addr      = a;
      bus.storeData = sd;
   endtask

   typedef struct {
      logic [31:0] mem1;
      logic        req;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [31:0] exp_load;
      logic        exp_fault;
      logic        exp_rd;
      logic        exp_wr;
      logic        exp_stall;
      logic [7:0]  exp_fcnt;
      logic [31:0] exp_lfa;
   } vec_t;

   vec_t vecs [16];

   initial begin
      int w0;
      vecs[0]  = '{32'h11223344, 1'b1, 1'b0, 3'b000, 32'h7,   32'h0,        32'h00000011, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0};
      vecs[1]  = '{32'h11223344, 1'b1, 1'b0, 3'b100, 32'h4,   32'h0,        32'h00000044, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0};
      vecs[2]  = '{32'h80FF7F00, 1'b1, 1'b0, 3'b001, 32'h6,   32'h0,        32'hFFFF80FF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0};
      vecs[3]  = '{32'h80FF7F00, 1'b1, 1'b0, 3'b000, 32'h5,   32'h0,        32'h0000007F, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0};
      vecs[4]  = '{32'h80FF7F00, 1'b1, 1'b0, 3'b000, 32'h6,   32'h0,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0};
      vecs[5]  = '{32'h80FF7F00, 1'b1, 1'b0, 3'b101, 32'h6,   32'h0,        32'h000080FF, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0};
      vecs[6]  = '{32'h80FF7F00, 1'b1, 1'b0, 3'b001, 32'h4,   32'h0,        32'h00007F00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0};
      vecs[7]  = '{32'h80FF7F00, 1'b1, 1'b0, 3'b010, 32'h4,   32'h0,        32'h80FF7F00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0};
      vecs[8]  = '{32'h80FF7F00, 1'b0, 1'b0, 3'b010, 32'h4,   32'h0,        32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0};
      vecs[9]  = '{32'h11223344, 1'b1, 1'b0, 3'b010, 32'h6,   32'h0,        32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 32'h6};
      vecs[10] = '{32'h11223344, 1'b1, 1'b0, 3'b010, 32'h800, 32'h0,        32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 32'h800};
      vecs[11] = '{32'h11223344, 1'b1, 1'b0, 3'b001, 32'h5,   32'h0,        32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 32'h5};
      vecs[12] = '{32'h11223344, 1'b1, 1'b1, 3'b100, 32'h4,   32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 32'h4};
      vecs[13] = '{32'h11223344, 1'b1, 1'b0, 3'b011, 32'hC,   32'h0,        32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 32'hC};
      vecs[14] = '{32'h11223344, 1'b1, 1'b0, 3'b010, 32'h7FC, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 32'hC};
      vecs[15] = '{32'h11223344, 1'b1, 1'b1, 3'b010, 32'h8,   32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5, 32'hC};

      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      mem[1]   = 32'h11223344;
      mem[2]   = 32'h55667788;
      mem[511] = 32'hCAFEF00D;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

      #3;
      check("reset stall", bus.stall, 32'h0);
      check("reset dmemRead", bus.dmemRead, 32'h0);
      check("reset dmemWrite", bus.dmemWrite, 32'h0);
      check("reset loadData", bus.loadData, 32'h0);
      check("reset faultCount", bus.faultCount, 32'h0);
      check("reset lastFaultAddr", bus.lastFaultAddr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset lands in the middle of an SB read-modify-write: the write must never happen.
      drive(1'b1, 1'b1, 3'b000, 32'h8, 32'h000000AB);
      @(negedge clk);
      check("rmwrst stall", bus.stall, 32'h1);
      check("rmwrst dmemRead", bus.dmemRead, 32'h1);
      tick();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 3'b000, 32'h8, 32'h0);
      #1;
      check("rmwrst dmemWrite", bus.dmemWrite, 32'h0);
      check("rmwrst stall after", bus.stall, 32'h0);
      check("rmwrst faultCount", bus.faultCount, 32'h0);
      @(negedge clk);
      tick();
      check("rmwrst mem[2]", mem[2], 32'h55667788);
      check("rmwrst write count", wr_cnt, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      tick();

      for (int i = 0; i < 16; i++) begin
         mem[1] = vecs[i].mem1;
         drive(vecs[i].req, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].sd);
         @(negedge clk);
         check($sformatf("vec%0d loadData", i), bus.loadData, vecs[i].exp_load);
         check($sformatf("vec%0d fault", i), bus.fault, 32'(vecs[i].exp_fault));
         check($sformatf("vec%0d dmemRead", i), bus.dmemRead, 32'(vecs[i].exp_rd));
         check($sformatf("vec%0d dmemWrite", i), bus.dmemWrite, 32'(vecs[i].exp_wr));
         check($sformatf("vec%0d stall", i), bus.stall, 32'(vecs[i].exp_stall));
         check($sformatf("vec%0d dmemAddr", i), bus.dmemAddr, {2'b00, vecs[i].addr[31:2]});
         tick();
         check($sformatf("vec%0d faultCount", i), bus.faultCount, 32'(vecs[i].exp_fcnt));
         check($sformatf("vec%0d lastFaultAddr", i), bus.lastFaultAddr, vecs[i].exp_lfa);
      end
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      check("sw mem[2]", mem[2], 32'hDEADBEEF);

      // SB 0xAB to 0x5, then an LW of the same word right after the RMW completes.
      mem[1] = 32'h11223344;
      w0 = wr_cnt;
      drive(1'b1, 1'b1, 3'b000, 32'h5, 32'hFFFFFFAB);
      @(negedge clk);
      check("sb c0 dmemRead", bus.dmemRead, 32'h1);
      check("sb c0 stall", bus.stall, 32'h1);
      check("sb c0 dmemWrite", bus.dmemWrite, 32'h0);
      tick();
      @(negedge clk);
      check("sb c1 dmemWrite", bus.dmemWrite, 32'h1);
      check("sb c1 dmemWriteData", bus.dmemWriteData, 32'h1122AB44);
      check("sb c1 stall", bus.stall, 32'h0);
      check("sb c1 dmemRead", bus.dmemRead, 32'h0);
      check("sb c1 fault", bus.fault, 32'h0);
      check("sb c1 dmemAddr", bus.dmemAddr, 32'h1);
      tick();
      drive(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
      @(negedge clk);
      check("lw after sb loadData", bus.loadData, 32'h1122AB44);
      check("lw after sb stall", bus.stall, 32'h0);
      check("lw after sb dmemRead", bus.dmemRead, 32'h1);
      tick();
      check("sb write count", wr_cnt - w0, 32'h1);

      // SH 0xBEEF to 0x6.
      mem[1] = 32'h11223344;
      drive(1'b1, 1'b1, 3'b001, 32'h6, 32'h1234BEEF);
      @(negedge clk);
      check("sh c0 stall", bus.stall, 32'h1);
      tick();
      @(negedge clk);
      check("sh c1 dmemWriteData", bus.dmemWriteData, 32'hBEEF3344);
      tick();
      check("sh mem[1]", mem[1], 32'hBEEF3344);

      // Five idle cycles with junk on the other inputs.
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 3'b000, 32'h10 + 32'(i), 32'hFFFFFFFF);
         @(negedge clk);
         check($sformatf("idle%0d dmemRead", i), bus.dmemRead, 32'h0);
         check($sformatf("idle%0d dmemWrite", i), bus.dmemWrite, 32'h0);
         check($sformatf("idle%0d stall", i), bus.stall, 32'h0);
         tick();
      end

      // 300 more misaligned LWs push the counter into saturation.
      drive(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         tick();
      end
      @(negedge clk);
      check("sat fault", bus.fault, 32'h1);
      check("sat dmemRead", bus.dmemRead, 32'h0);
      tick();
      check("sat faultCount", bus.faultCount, 32'd255);
      check("sat lastFaultAddr", bus.lastFaultAddr, 32'h6);
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage front end sitting directly upstream of the data memory in the 3-stage pipeline.
- Converts byte-addressed RV32 load/store requests from execute into word-indexed data-memory accesses.
- Implements sub-word stores as a 2-cycle read-modify-write, because the data memory writes whole words only.
- Sign/zero-extends load results and flags misaligned or out-of-range accesses.

Parameters:
DEPTH, 512, number of 32-bit words in data memory; word index >= DEPTH is a fault
FCNT_W, 8, width of saturating fault counter

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
memReq  in  1  valid memory instruction in this stage
memWe  in  1  1=store, 0=load
funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
addr  in  32  byte address from ALU
storeData  in  32  rs2 value
loadData  out  32  extended load result to writeback
stall  out  1  freeze upstream pipeline registers
fault  out  1  access fault this cycle (combinational)
faultCount  out  FCNT_W  saturating count of faults
lastFaultAddr  out  32  byte address of most recent fault
dmemRead  out  1  to data memory MemRead
dmemWrite  out  1  to data memory MemWrite
dmemAddr  out  32  word index = {2'b0, addr[31:2]}
dmemWriteData  out  32  word to write
dmemReadData  in  32  combinational read word from data memory

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mergeReg=0; faultCount=0; lastFaultAddr=0. Outputs then: stall=0, dmemRead=0, dmemWrite=0, loadData=0.
- Fault decode (IDLE, memReq=1) asserts fault on any of:
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - addr[31:2] >= DEPTH.
  - store with funct3 not in {000,001,010}.
  - load with funct3 not in {000,001,010,100,101}.
- On fault:
  - No dmemRead/dmemWrite; loadData=0; stall=0.
  - Registered at that clock edge: faultCount +1, saturating at all-ones; lastFaultAddr<=addr.
- Lane: byte lane = addr[1:0]; half lane = addr[1].
- Load (IDLE, no fault), single cycle, stall=0:
  - dmemRead=1.
  - Selected byte/half is taken from dmemReadData, then sign-extended (B/H) or zero-extended (BU/HU); W passes through.
  - Example: lane 2 byte = dmemReadData[23:16].
- SW (IDLE, no fault), single cycle, stall=0: dmemWrite=1; dmemWriteData=storeData.
- SB/SH (no fault), FSM IDLE -> RMW -> IDLE:
  - IDLE cycle: dmemRead=1, stall=1, dmemWrite=0. At the clock edge mergeReg<=dmemReadData with the target lane replaced by storeData[7:0] or [15:0]; state<=RMW.
  - RMW cycle: dmemWrite=1; dmemWriteData=mergeReg; dmemAddr unchanged (upstream holds inputs stable while stall=1); stall=0; dmemRead=0; inputs not re-decoded; fault=0. Next state IDLE.
  - Pipeline advances at the end of the RMW cycle. Sub-word store latency = 2 cycles; all other accesses = 1 cycle.
- memReq=0 in IDLE: all dmem strobes 0, stall=0, loadData=0, state stays IDLE.
- Reset asserted during RMW: state->IDLE immediately; write suppressed; memory is left unmodified.
- dmemAddr is driven combinationally from addr in all states. Upper bits are zero-padded.
- No back-to-back hazard: the next instruction cannot issue until RMW completes, because stall holds it.

Test Plan:
1. Reset with rst_n=0 mid-RMW (SB to addr 0x8 in progress) -> state IDLE, dmemWrite never pulses, faultCount=0, stall=0.
2. Word 0x11223344 preloaded at index 1; LB addr 0x7 -> loadData=0x00000011. LBU addr 0x4 -> 0x00000044. Same word at 0x80FF7F00 with LH addr 0x6 -> 0xFFFF80FF. All single cycle, stall=0.
3. SB storeData=0xAB to addr 0x5, mem[1]=0x11223344:
   - cycle 0: dmemRead=1, stall=1.
   - cycle 1: dmemWrite=1, dmemWriteData=0x1122AB44, stall=0.
   - A following LW 0x4 returns 0x1122AB44.
4. SH 0xBEEF to addr 0x6 over 0x11223344 -> written 0xBEEF3344. SW 0xDEADBEEF to 0x8 -> one-cycle write, no stall.
5. LW addr 0x6 -> fault=1, no strobes, lastFaultAddr=0x6, faultCount=1. Addr 0x800 (index 512) -> fault, faultCount=2. Drive 300 faults -> faultCount saturates at 255.
6. memReq=0 for 5 cycles between accesses -> no strobes, stall=0. SB immediately followed by LW -> LW held stable until the RMW cycle completes, then issues.
